// File: rtl/alu_issue_queue.sv
// alu_issue_queue: collapsing issue queue in front of a combinational ALU.
// Ops wait here until both source operands are valid. Missing operands are
// captured from the CDB. The oldest ready op drives the ALU, and the ALU
// result is registered into a single writeback slot with a valid/ready
// handshake.
module alu_issue_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             disp_valid,
    output logic             disp_ready,
    input  logic [159:0]     disp_data,
    input  logic             disp_rs1_rdy,
    input  logic             disp_rs2_rdy,
    input  logic [4:0]       disp_rs1_tag,
    input  logic [4:0]       disp_rs2_tag,
    input  logic             cdb_valid,
    input  logic [4:0]       cdb_tag,
    input  logic [63:0]      cdb_data,
    output logic             alu_en,
    output logic [159:0]     alu_data_in,
    input  logic [73:0]      alu_data_out,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [73:0]      wb_data,
    output logic [CNT_W-1:0] occupancy
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // Held entries: control bits (reset) and payload (not reset)
    logic [DEPTH-1:0] ent_vld;
    logic [DEPTH-1:0] ent_rdy1;
    logic [DEPTH-1:0] ent_rdy2;
    logic [4:0]       ent_tag1 [DEPTH];
    logic [4:0]       ent_tag2 [DEPTH];
    logic [159:0]     ent_pkt  [DEPTH];

    // Entries after CDB wakeup; index DEPTH is an empty slot that shifts
    // into the top position when the queue collapses.
    logic [DEPTH:0]   wk_vld;
    logic [DEPTH:0]   wk_rdy1;
    logic [DEPTH:0]   wk_rdy2;
    logic [4:0]       wk_tag1 [DEPTH+1];
    logic [4:0]       wk_tag2 [DEPTH+1];
    logic [159:0]     wk_pkt  [DEPTH+1];

    // Next-state image of the queue
    logic [DEPTH-1:0] nx_vld;
    logic [DEPTH-1:0] nx_rdy1;
    logic [DEPTH-1:0] nx_rdy2;
    logic [4:0]       nx_tag1 [DEPTH];
    logic [4:0]       nx_tag2 [DEPTH];
    logic [159:0]     nx_pkt  [DEPTH];

    logic             any_ready;
    logic             issue_ok;
    logic             issue;
    logic             accept;
    logic [CNT_W-1:0] sel;
    logic [CNT_W-1:0] wr_slot;
    logic [159:0]     sel_pkt;
    logic             cap1;
    logic             cap2;
    logic [159:0]     disp_pkt;

    // Oldest ready entry: scan downward so the lowest index wins.
    always_comb begin
        any_ready = 1'b0;
        sel       = '0;
        sel_pkt   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ent_vld[i] && ent_rdy1[i] && ent_rdy2[i]) begin
                any_ready = 1'b1;
                sel       = CNT_W'(i);
                sel_pkt   = ent_pkt[i];
            end
        end
    end

    assign issue_ok    = (!wb_valid || wb_ready) && !flush;
    assign issue       = issue_ok && any_ready;
    assign alu_en      = issue;
    assign alu_data_in = issue ? sel_pkt : '0;
    assign disp_ready  = (occupancy < DEPTH_C) && !flush;
    assign accept      = disp_valid && disp_ready;
    // A same-edge issue frees one slot below the current tail.
    assign wr_slot     = occupancy - CNT_W'(issue);

    // CDB wakeup of held entries; rs1 and rs2 match independently.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            wk_vld[i]  = ent_vld[i];
            wk_rdy1[i] = ent_rdy1[i];
            wk_rdy2[i] = ent_rdy2[i];
            wk_tag1[i] = ent_tag1[i];
            wk_tag2[i] = ent_tag2[i];
            wk_pkt[i]  = ent_pkt[i];
            if (ent_vld[i] && cdb_valid && !ent_rdy1[i] && (ent_tag1[i] == cdb_tag)) begin
                wk_rdy1[i]          = 1'b1;
                wk_pkt[i][159:96]   = cdb_data;
            end
            if (ent_vld[i] && cdb_valid && !ent_rdy2[i] && (ent_tag2[i] == cdb_tag)) begin
                wk_rdy2[i]          = 1'b1;
                wk_pkt[i][95:32]    = cdb_data;
            end
        end
        wk_vld[DEPTH]  = 1'b0;
        wk_rdy1[DEPTH] = 1'b0;
        wk_rdy2[DEPTH] = 1'b0;
        wk_tag1[DEPTH] = '0;
        wk_tag2[DEPTH] = '0;
        wk_pkt[DEPTH]  = '0;
    end

    // Operands broadcast in the dispatch cycle are captured on entry.
    always_comb begin
        cap1     = !disp_rs1_rdy && cdb_valid && (disp_rs1_tag == cdb_tag);
        cap2     = !disp_rs2_rdy && cdb_valid && (disp_rs2_tag == cdb_tag);
        disp_pkt = disp_data;
        if (cap1) disp_pkt[159:96] = cdb_data;
        if (cap2) disp_pkt[95:32]  = cdb_data;
    end

    // Collapse entries above the issued slot, then append the dispatch.
    always_comb begin
        for (int j = 0; j < DEPTH; j++) begin
            if (issue && (CNT_W'(j) >= sel)) begin
                nx_vld[j]  = wk_vld[j+1];
                nx_rdy1[j] = wk_rdy1[j+1];
                nx_rdy2[j] = wk_rdy2[j+1];
                nx_tag1[j] = wk_tag1[j+1];
                nx_tag2[j] = wk_tag2[j+1];
                nx_pkt[j]  = wk_pkt[j+1];
            end else begin
                nx_vld[j]  = wk_vld[j];
                nx_rdy1[j] = wk_rdy1[j];
                nx_rdy2[j] = wk_rdy2[j];
                nx_tag1[j] = wk_tag1[j];
                nx_tag2[j] = wk_tag2[j];
                nx_pkt[j]  = wk_pkt[j];
            end
            if (accept && (CNT_W'(j) == wr_slot)) begin
                nx_vld[j]  = 1'b1;
                nx_rdy1[j] = disp_rs1_rdy || cap1;
                nx_rdy2[j] = disp_rs2_rdy || cap2;
                nx_tag1[j] = disp_rs1_tag;
                nx_tag2[j] = disp_rs2_tag;
                nx_pkt[j]  = disp_pkt;
            end
        end
    end

    // Control state: entry flags, occupancy and the writeback slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_vld   <= '0;
            ent_rdy1  <= '0;
            ent_rdy2  <= '0;
            occupancy <= '0;
            wb_valid  <= 1'b0;
            wb_data   <= '0;
        end else if (flush) begin
            ent_vld   <= '0;
            occupancy <= '0;
            wb_valid  <= 1'b0;
        end else begin
            ent_vld   <= nx_vld;
            ent_rdy1  <= nx_rdy1;
            ent_rdy2  <= nx_rdy2;
            occupancy <= occupancy + CNT_W'(accept) - CNT_W'(issue);
            if (issue) begin
                wb_valid <= 1'b1;
                wb_data  <= alu_data_out;
            end else if (wb_valid && wb_ready) begin
                wb_valid <= 1'b0;
            end
        end
    end

    // Payload storage; only meaningful where the matching valid bit is set.
    always_ff @(posedge clk) begin
        for (int j = 0; j < DEPTH; j++) begin
            ent_tag1[j] <= nx_tag1[j];
            ent_tag2[j] <= nx_tag2[j];
            ent_pkt[j]  <= nx_pkt[j];
        end
    end

endmodule

// File: tb/tb_alu_issue_queue.sv
// tb_alu_issue_queue: directed scenarios plus randomized traffic, each cycle
// compared against an in-order queue model of the scheduler.
module tb_alu_issue_queue;

    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             disp_valid;
    logic             disp_ready;
    logic [159:0]     disp_data;
    logic             disp_rs1_rdy;
    logic             disp_rs2_rdy;
    logic [4:0]       disp_rs1_tag;
    logic [4:0]       disp_rs2_tag;
    logic             cdb_valid;
    logic [4:0]       cdb_tag;
    logic [63:0]      cdb_data;
    logic             alu_en;
    logic [159:0]     alu_data_in;
    logic [73:0]      alu_data_out;
    logic             wb_valid;
    logic             wb_ready;
    logic [73:0]      wb_data;
    logic [CNT_W-1:0] occupancy;

    always #5 clk = ~clk;

    alu_issue_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_data(disp_data),
        .disp_rs1_rdy(disp_rs1_rdy), .disp_rs2_rdy(disp_rs2_rdy),
        .disp_rs1_tag(disp_rs1_tag), .disp_rs2_tag(disp_rs2_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .alu_en(alu_en), .alu_data_in(alu_data_in), .alu_data_out(alu_data_out),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
        .occupancy(occupancy)
    );

    // Small ALU stand-in
    function automatic logic [63:0] alu_fn(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
        case (op)
            5'd1:    return a + b;
            5'd2:    return a - b;
            5'd3:    return a ^ b;
            default: return a & b;
        endcase
    endfunction

    always_comb alu_data_out = {alu_fn(alu_data_in[9:5], alu_data_in[159:96], alu_data_in[95:32]),
                                alu_data_in[31:27], alu_data_in[4:0]};

    // Reference model: queue in age order
    typedef struct {
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic        r1;
        logic        r2;
        logic [4:0]  t1;
        logic [4:0]  t2;
        logic [31:0] rest;
    } ent_t;

    ent_t        mq[$];
    logic        m_wbv = 1'b0;
    logic [73:0] m_wbd = '0;
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle();
        flush        = 1'b0;
        disp_valid   = 1'b0;
        disp_data    = '0;
        disp_rs1_rdy = 1'b1;
        disp_rs2_rdy = 1'b1;
        disp_rs1_tag = '0;
        disp_rs2_tag = '0;
        cdb_valid    = 1'b0;
        cdb_tag      = '0;
        cdb_data     = '0;
    endtask

    task automatic disp(input logic [63:0] a, input logic [63:0] b, input logic ra, input logic rb,
                        input logic [4:0] ta, input logic [4:0] tb, input logic [4:0] rd,
                        input logic [4:0] op, input logic [4:0] itag);
        logic [11:0] imm;
        logic [4:0]  opt;
        imm = 12'($urandom);
        opt = 5'($urandom);
        disp_valid   = 1'b1;
        disp_data    = {a, b, rd, imm, opt, op, itag};
        disp_rs1_rdy = ra;
        disp_rs2_rdy = rb;
        disp_rs1_tag = ta;
        disp_rs2_tag = tb;
    endtask

    // One cycle: inputs already driven after a falling edge; check, advance model, clock.
    task automatic step();
        int           k;
        int           sz;
        logic         een;
        logic [159:0] epkt;
        ent_t         e;
        #2;
        sz = mq.size();
        k  = -1;
        for (int i = 0; i < sz; i++)
            if (k < 0 && mq[i].r1 && mq[i].r2) k = i;
        een  = ((!m_wbv || wb_ready) && !flush) && (k >= 0);
        epkt = '0;
        if (een) epkt = {mq[k].rs1, mq[k].rs2, mq[k].rest};
        chk("alu_en", alu_en, een);
        chk("alu_data_in", alu_data_in, epkt);
        chk("disp_ready", disp_ready, (sz < DEPTH) && !flush);
        chk("occupancy", occupancy, sz);
        chk("wb_valid", wb_valid, m_wbv);
        if (m_wbv) chk("wb_data", wb_data, m_wbd);
        if (flush) begin
            mq.delete();
            m_wbv = 1'b0;
        end else begin
            if (een) begin
                e     = mq[k];
                m_wbv = 1'b1;
                m_wbd = {alu_fn(e.rest[9:5], e.rs1, e.rs2), e.rest[31:27], e.rest[4:0]};
                mq.delete(k);
            end else if (m_wbv && wb_ready) begin
                m_wbv = 1'b0;
            end
            for (int i = 0; i < mq.size(); i++) begin
                if (cdb_valid && !mq[i].r1 && mq[i].t1 == cdb_tag) begin mq[i].r1 = 1'b1; mq[i].rs1 = cdb_data; end
                if (cdb_valid && !mq[i].r2 && mq[i].t2 == cdb_tag) begin mq[i].r2 = 1'b1; mq[i].rs2 = cdb_data; end
            end
            if (disp_valid && sz < DEPTH) begin
                e.rs1  = disp_data[159:96];
                e.rs2  = disp_data[95:32];
                e.rest = disp_data[31:0];
                e.r1   = disp_rs1_rdy;
                e.r2   = disp_rs2_rdy;
                e.t1   = disp_rs1_tag;
                e.t2   = disp_rs2_tag;
                if (cdb_valid && !e.r1 && e.t1 == cdb_tag) begin e.r1 = 1'b1; e.rs1 = cdb_data; end
                if (cdb_valid && !e.r2 && e.t2 == cdb_tag) begin e.r2 = 1'b1; e.rs2 = cdb_data; end
                mq.push_back(e);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_occ"}, occupancy, 0);
        chk({tag, "_wbv"}, wb_valid, 0);
        chk({tag, "_wbd"}, wb_data, 0);
        chk({tag, "_en"}, alu_en, 0);
        chk({tag, "_pkt"}, alu_data_in, 0);
        chk({tag, "_drdy"}, disp_ready, 1);
    endtask

    initial begin
        idle();
        wb_ready = 1'b1;
        rst      = 1'b1;
        #1;
        chk_reset_outputs("rst0");
        @(negedge clk);
        rst = 1'b0;

        // Ready add issues the cycle after dispatch
        disp(64'd5, 64'd7, 1'b1, 1'b1, 5'd0, 5'd0, 5'd9, 5'd1, 5'd3);
        step();
        idle();
        step();
        chk("t1_wb", wb_data, {64'd12, 5'd9, 5'd3});
        chk("t1_wbv", wb_valid, 1);
        step();

        // Younger ready op bypasses a waiting one; CDB wakes the older op
        disp(64'd0, 64'd20, 1'b0, 1'b1, 5'd6, 5'd0, 5'd2, 5'd1, 5'd10);
        step();
        disp(64'd1, 64'd2, 1'b1, 1'b1, 5'd0, 5'd0, 5'd3, 5'd3, 5'd11);
        step();
        idle();
        cdb_valid = 1'b1; cdb_tag = 5'd6; cdb_data = 64'd100;
        step();
        chk("t2_b_wb", wb_data, {64'd3, 5'd3, 5'd11});
        idle();
        step();
        chk("t2_a_wb", wb_data, {64'd120, 5'd2, 5'd10});
        step();

        // Writeback back-pressure fills the queue
        wb_ready = 1'b0;
        for (int n = 0; n < 6; n++) begin
            disp(64'(n + 1), 64'(n * 3), 1'b1, 1'b1, 5'd0, 5'd0, 5'(n), 5'd1, 5'(n + 16));
            step();
        end
        idle();
        chk("t3_occ", occupancy, 4);
        chk("t3_wb_held", wb_data, {64'd1, 5'd0, 5'd16});
        wb_ready = 1'b1;
        for (int n = 0; n < 6; n++) step();

        // Operand broadcast in the dispatch cycle is captured
        disp(64'h10, 64'd0, 1'b1, 1'b0, 5'd0, 5'd4, 5'd7, 5'd1, 5'd7);
        cdb_valid = 1'b1; cdb_tag = 5'd4; cdb_data = 64'hFF;
        step();
        idle();
        step();
        chk("t4_wb", wb_data, {64'h10F, 5'd7, 5'd7});
        step();

        // Flush with a dropped simultaneous dispatch
        wb_ready = 1'b0;
        for (int n = 0; n < 4; n++) begin
            disp(64'(n), 64'd1, 1'b1, 1'b1, 5'd0, 5'd0, 5'd1, 5'd2, 5'(n));
            step();
        end
        idle();
        disp(64'd9, 64'd9, 1'b1, 1'b1, 5'd0, 5'd0, 5'd1, 5'd1, 5'd30);
        flush = 1'b1;
        step();
        idle();
        chk("t5_occ", occupancy, 0);
        chk("t5_wbv", wb_valid, 0);
        step();

        // Asynchronous reset mid-cycle
        for (int n = 0; n < 3; n++) begin
            disp(64'(n + 4), 64'd2, 1'b1, 1'b1, 5'd0, 5'd0, 5'd1, 5'd1, 5'(n));
            step();
        end
        idle();
        #3;
        rst = 1'b1;
        #1;
        chk_reset_outputs("rst1");
        mq.delete();
        m_wbv = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            idle();
            wb_ready = ($urandom_range(0, 9) < 7);
            flush    = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 9) < 6)
                disp({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                     5'($urandom), 5'($urandom_range(0, 4)), 5'($urandom));
            if ($urandom_range(0, 9) < 4) begin
                cdb_valid = 1'b1;
                cdb_tag   = 5'($urandom_range(0, 3));
                cdb_data  = {$urandom, $urandom};
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_issue_queue.md
Name: alu_issue_queue

Overview:
- DEPTH-entry issue queue and scheduler in front of the combinational ALU.
- Holds dispatched ALU ops until both source operands are valid, capturing late operands from the common data bus (CDB).
- Selects the oldest ready entry each cycle and drives the ALU enable and 160-bit operand packet.
- Registers the ALU's 74-bit result into a writeback stage with a valid/ready handshake.

Parameters:
- DEPTH, 4, number of queue entries (2..8).
- CNT_W, 3, width of occupancy count; must satisfy 2^CNT_W > DEPTH.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  discard all queued ops and the writeback entry.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  queue can accept a dispatch.
- disp_data  in  160  packet {rs1[63:0], rs2[63:0], rd_idex[4:0], imm[11:0], op_type[4:0], op[4:0], itag[4:0]}, MSB first.
- disp_rs1_rdy  in  1  rs1 field holds a valid value.
- disp_rs2_rdy  in  1  rs2 field holds a valid value.
- disp_rs1_tag  in  5  producer itag for rs1 when not ready.
- disp_rs2_tag  in  5  producer itag for rs2 when not ready.
- cdb_valid  in  1  result broadcast valid.
- cdb_tag  in  5  itag of broadcast result.
- cdb_data  in  64  broadcast value.
- alu_en  out  1  ALU enable.
- alu_data_in  out  160  packet to ALU, same packing as disp_data.
- alu_data_out  in  74  ALU result {rd_wb[63:0], rd_idex[4:0], itag[4:0]}.
- wb_valid  out  1  writeback entry valid.
- wb_ready  in  1  writeback consumer accepts.
- wb_data  out  74  registered ALU result.
- occupancy  out  CNT_W  number of valid entries.

Behaviour:
- Reset (asynchronous): all entries invalid, occupancy=0, wb_valid=0, wb_data=0, disp_ready=1; alu_en=0 and alu_data_in=0 follow combinationally.
- Queue ordering:
  - Collapsing queue: entry 0 is oldest; valid entries always occupy 0..occupancy-1.
  - On issue of entry k, entries k+1.. shift down one slot on the same edge.
- Ready: entry is ready when valid, rs1_rdy=1 and rs2_rdy=1.
- Issue condition: issue_ok = (wb_valid==0) | wb_ready, and no flush.
- Select: lowest-index ready entry. When issue_ok and a ready entry exists:
  - alu_en=1, alu_data_in = that entry's packet (combinational, same cycle).
  - At the edge: wb_data <= alu_data_out, wb_valid <= 1, entry removed.
  - Otherwise alu_en=0 and alu_data_in=0.
- Writeback: when wb_valid & wb_ready and no new issue, wb_valid <= 0 at the edge. Issue and drain in the same cycle keep wb_valid=1 with the new data. wb_data holds stable while wb_valid & !wb_ready.
- Latency: dispatch accepted at edge t; earliest alu_en in cycle t..t+1 (entry visible after t); wb_valid from edge t+1 onward. Minimum dispatch-to-wb_valid is 2 edges.
- Wakeup:
  - Each edge, for every valid entry whose operand is not ready with tag==cdb_tag and cdb_valid, write cdb_data into that operand field and set its rdy.
  - rs1 and rs2 wake independently; both wake if both tags match.
  - A woken entry is eligible for issue in the following cycle, never in the wakeup cycle.
- Dispatch:
  - disp_ready = (occupancy < DEPTH) & !flush.
  - An accepted op is written at slot occupancy, or occupancy-1 if an issue happens the same edge.
  - A not-ready operand whose tag matches an active CDB in the dispatch cycle is captured as ready.
  - Full + simultaneous issue does not accept dispatch (disp_ready already 0).
- Occupancy: +1 on dispatch, -1 on issue, unchanged on both.
- Flush: at the edge, all entries invalid, occupancy=0, wb_valid=0. Issue and dispatch in the flush cycle are dropped; alu_en=0 during flush.
- Operand values of not-ready operands are don't-care until wakeup. imm, op_type, op, rd_idex and itag pass through unmodified.

Test Plan:
- Ready add, op=1, rs1=5, rs2=7, itag=3, rd_idex=9, wb_ready=1 → alu_en=1 the cycle after dispatch; wb_data={64'd12, 5'd9, 5'd3} with wb_valid=1 after the next edge.
- Entry A (rs1 waits on tag 6), then ready entry B → B issues first. cdb_valid, tag=6, data=100 → A issues the following cycle using rs1=100.
- Four ready dispatches, wb_ready=0 → after the first issue, alu_en=0 and wb_data held. occupancy=3, fifth dispatch with disp_ready=1 accepted, sixth blocked (disp_ready=0). Raise wb_ready → one issue per cycle in dispatch order.
- Dispatch with rs2 tag=4, not ready, while cdb_valid, tag=4, data=0xFF in the same cycle → entry issues next cycle with rs2=0xFF.
- Three entries queued with wb_valid=1; assert flush one cycle → occupancy=0, wb_valid=0, alu_en=0. A simultaneous dispatch is dropped.
- Assert rst mid-stream with entries and wb_valid set → outputs reach reset values immediately without a clock edge.
